// File: rtl/snake_game_ctrl_pkg.sv
// rtl/snake_game_ctrl_pkg.sv - shared game state encoding, default constants and move-period helper
package snake_game_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_START = 3'd0,
      ST_PLAY  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_PAUSE = 3'd3,
      ST_WIN   = 3'd4,
      ST_OVER  = 3'd5
   } game_state_t;

   localparam int unsigned DEF_BODY_MAX  = 128;
   localparam int unsigned DEF_TICK_BASE = 10_000_000;
   localparam int unsigned DEF_TICK_STEP = 500_000;
   localparam int unsigned DEF_TICK_MIN  = 4_500_000;
   localparam int unsigned DEF_LEVELS    = 10;
   localparam int unsigned DEF_WIN_SCORE = 3;

   // max(base - lvl*step, min_p) without letting the subtraction wrap
   function automatic logic [31:0] calc_period(input logic [31:0] base,
                                               input logic [31:0] step,
                                               input logic [31:0] min_p,
                                               input logic [3:0]  lvl);
      logic [31:0] dec;
      dec = step * {28'd0, lvl};
      if (dec >= base)
         calc_period = min_p;
      else if ((base - dec) < min_p)
         calc_period = min_p;
      else
         calc_period = base - dec;
   endfunction

endpackage

// File: rtl/snake_game_ctrl_if.sv
// rtl/snake_game_ctrl_if.sv - move request/result handshake between sequencer and datapath
interface snake_game_ctrl_if;
   logic move_req;
   logic grow;
   logic respawn;
   logic clear;
   logic move_ack;
   logic eat;
   logic hit_wall;
   logic hit_body;

   modport ctrl (
      output move_req, grow, respawn, clear,
      input  move_ack, eat, hit_wall, hit_body
   );

   modport dp (
      input  move_req, grow, respawn, clear,
      output move_ack, eat, hit_wall, hit_body
   );
endinterface

// File: rtl/snake_game_ctrl_tick_timer.sv
// rtl/snake_game_ctrl_tick_timer.sv - level-dependent move period counter with clear, hold and expire
module snake_tick_timer
   import snake_game_ctrl_pkg::*;
#(
   parameter int unsigned TICK_BASE = DEF_TICK_BASE,
   parameter int unsigned TICK_STEP = DEF_TICK_STEP,
   parameter int unsigned TICK_MIN  = DEF_TICK_MIN
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] i_level,
   input  logic       i_clear,
   input  logic       i_hold,
   output logic       o_expire
);

   logic [31:0] r_count;
   logic [31:0] w_period;

   assign w_period = calc_period(TICK_BASE, TICK_STEP, TICK_MIN, i_level);
   assign o_expire = !i_hold && !i_clear && (r_count == (w_period - 32'd1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_count <= 32'd0;
      else if (i_clear || o_expire)
         r_count <= 32'd0;
      else if (!i_hold)
         r_count <= r_count + 32'd1;
   end

endmodule

// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - snake game sequencer: state, move scheduling, score/length/level
// Optional pause support is compiled in with SNAKE_PAUSE_EN.
module snake_game_ctrl
   import snake_game_ctrl_pkg::*;
#(
   parameter int unsigned TICK_BASE = DEF_TICK_BASE,
   parameter int unsigned TICK_STEP = DEF_TICK_STEP,
   parameter int unsigned TICK_MIN  = DEF_TICK_MIN,
   parameter int unsigned LEVELS    = DEF_LEVELS,
   parameter int unsigned WIN_SCORE = DEF_WIN_SCORE,
   parameter int unsigned BODY_MAX  = DEF_BODY_MAX
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_start,
   input  logic              i_pause,
   snake_game_ctrl_if.ctrl   dp_if,
   output game_state_t       o_state,
   output logic [15:0]       o_score,
   output logic [6:0]        o_length,
   output logic [3:0]        o_level
);

   game_state_t r_state;
   logic        r_move_req;
   logic        r_grow;
   logic        r_respawn;
   logic        r_clear;
   logic        r_grow_pend;
   logic        r_pause_pend;
   logic [15:0] r_score;
   logic [6:0]  r_length;
   logic [3:0]  r_level;

   logic        w_pause;
   logic        w_hold;
   logic        w_expire;
   logic        w_tmr_clear;
   logic        w_ack;
   logic        w_hit;
   logic [15:0] w_score_inc;
   game_state_t w_resume;

`ifdef SNAKE_PAUSE_EN
   assign w_pause = i_pause;
`else
   logic w_unused_pause;
   assign w_unused_pause = i_pause;
   assign w_pause        = 1'b0;
`endif

   assign w_ack       = (r_state == ST_WAIT) && dp_if.move_ack;
   assign w_hit       = dp_if.hit_wall | dp_if.hit_body;
   assign w_score_inc = (r_score == 16'hFFFF) ? r_score : r_score + 16'd1;
   // a pause seen while waiting on the datapath takes effect once the move lands
   assign w_resume    = (r_pause_pend || w_pause) ? ST_PAUSE : ST_PLAY;
   assign w_hold      = (r_state != ST_PLAY) || w_pause;
   assign w_tmr_clear = ((r_state == ST_START) && i_start) ||
                        (w_ack && !w_hit && dp_if.eat);

   snake_tick_timer #(
      .TICK_BASE (TICK_BASE),
      .TICK_STEP (TICK_STEP),
      .TICK_MIN  (TICK_MIN)
   ) u_timer (
      .clk      (clk),
      .rst_n    (reset_n),
      .i_level  (r_level),
      .i_clear  (w_tmr_clear),
      .i_hold   (w_hold),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_START;
         r_move_req   <= 1'b0;
         r_grow       <= 1'b0;
         r_respawn    <= 1'b0;
         r_clear      <= 1'b0;
         r_grow_pend  <= 1'b0;
         r_pause_pend <= 1'b0;
         r_score      <= 16'd0;
         r_length     <= 7'd0;
         r_level      <= 4'd0;
      end else begin
         r_clear   <= 1'b0;
         r_respawn <= 1'b0;
         case (r_state)
            ST_START: begin
               if (i_start) begin
                  r_state      <= ST_PLAY;
                  r_clear      <= 1'b1;
                  r_score      <= 16'd0;
                  r_length     <= 7'd0;
                  r_level      <= 4'd0;
                  r_grow_pend  <= 1'b0;
                  r_pause_pend <= 1'b0;
               end
            end
            ST_PLAY: begin
               if (w_pause) begin
                  r_state <= ST_PAUSE;
               end else if (w_expire) begin
                  r_move_req <= 1'b1;
                  r_grow     <= r_grow_pend;
                  r_state    <= ST_WAIT;
               end
            end
            ST_PAUSE: begin
               if (w_pause)
                  r_state <= ST_PLAY;
            end
            ST_WAIT: begin
               if (w_pause)
                  r_pause_pend <= 1'b1;
               if (dp_if.move_ack) begin
                  r_move_req   <= 1'b0;
                  r_grow       <= 1'b0;
                  r_pause_pend <= 1'b0;
                  if (r_grow) begin
                     r_grow_pend <= 1'b0;
                     if (r_length < 7'(BODY_MAX - 1))
                        r_length <= r_length + 7'd1;
                  end
                  // collision outranks a simultaneous eat
                  if (w_hit) begin
                     r_state <= ST_OVER;
                  end else if (dp_if.eat) begin
                     r_score     <= w_score_inc;
                     r_grow_pend <= 1'b1;
                     r_respawn   <= 1'b1;
                     if (r_level < 4'(LEVELS - 1))
                        r_level <= r_level + 4'd1;
                     r_state <= (w_score_inc >= 16'(WIN_SCORE)) ? ST_WIN : w_resume;
                  end else begin
                     r_state <= w_resume;
                  end
               end
            end
            ST_WIN, ST_OVER: begin
               if (i_start) begin
                  r_state <= ST_START;
                  r_clear <= 1'b1;
               end
            end
            default: r_state <= ST_START;
         endcase
      end
   end

   assign dp_if.move_req = r_move_req;
   assign dp_if.grow     = r_grow;
   assign dp_if.respawn  = r_respawn;
   assign dp_if.clear    = r_clear;
   assign o_state        = r_state;
   assign o_score        = r_score;
   assign o_length       = r_length;
   assign o_level        = r_level;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb/tb_snake_game_ctrl.sv - randomized self-checking bench for snake_game_ctrl
module tb_snake_game_ctrl;
   import snake_game_ctrl_pkg::*;

`ifdef SNAKE_PAUSE_EN
   localparam bit PAUSE_EN = 1'b1;
`else
   localparam bit PAUSE_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   logic sel;
   logic t_start, t_pause, t_ack, t_eat, t_wall, t_body;

   always #5 clk = ~clk;

   snake_game_ctrl_if ifa ();
   snake_game_ctrl_if ifb ();

   assign ifa.move_ack = t_ack  & ~sel;
   assign ifa.eat      = t_eat  & ~sel;
   assign ifa.hit_wall = t_wall & ~sel;
   assign ifa.hit_body = t_body & ~sel;
   assign ifb.move_ack = t_ack  & sel;
   assign ifb.eat      = t_eat  & sel;
   assign ifb.hit_wall = t_wall & sel;
   assign ifb.hit_body = t_body & sel;

   game_state_t st_a, st_b;
   logic [15:0] sc_a, sc_b;
   logic [6:0]  ln_a, ln_b;
   logic [3:0]  lv_a, lv_b;

   snake_game_ctrl #(.TICK_BASE(20), .TICK_STEP(4), .TICK_MIN(8), .LEVELS(4), .WIN_SCORE(3)) u_dut (
      .clk(clk), .reset_n(reset_n), .i_start(t_start & ~sel), .i_pause(t_pause & ~sel),
      .dp_if(ifa), .o_state(st_a), .o_score(sc_a), .o_length(ln_a), .o_level(lv_a));

   // second instance with an unreachable win score so level/length saturation can be reached
   snake_game_ctrl #(.TICK_BASE(20), .TICK_STEP(4), .TICK_MIN(8), .LEVELS(4), .WIN_SCORE(1000)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .i_start(t_start & sel), .i_pause(t_pause & sel),
      .dp_if(ifb), .o_state(st_b), .o_score(sc_b), .o_length(ln_b), .o_level(lv_b));

   logic        o_move_req, o_grow, o_respawn, o_clear;
   logic [2:0]  o_state;
   logic [15:0] o_score;
   logic [6:0]  o_length;
   logic [3:0]  o_level;

   assign o_move_req = sel ? ifb.move_req : ifa.move_req;
   assign o_grow     = sel ? ifb.grow     : ifa.grow;
   assign o_respawn  = sel ? ifb.respawn  : ifa.respawn;
   assign o_clear    = sel ? ifb.clear    : ifa.clear;
   assign o_state    = sel ? st_b : st_a;
   assign o_score    = sel ? sc_b : sc_a;
   assign o_length   = sel ? ln_b : ln_a;
   assign o_level    = sel ? lv_b : lv_a;

   int n_chk = 0;
   int n_fail = 0;

   logic [2:0] m_state;
   int  m_score, m_len, m_lvl, m_win;
   bit  m_gpend;
   int  g_since;

   function automatic int exp_period(input int lvl);
      int p;
      p = 20 - lvl * 4;
      return (p < 8) ? 8 : p;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_move(input int n0, output int n);
      n = n0;
      while (!o_move_req && n < 300) begin
         cyc();
         n++;
         if (n == 1) begin
            n_chk++;
            if ({o_respawn, o_clear} !== 2'b00) begin
               n_fail++;
               $display("FAIL pulses_low: got respawn/clear %b expected 00", {o_respawn, o_clear});
            end
         end
      end
   endtask

   task automatic ack_phase(input bit e, input bit w, input bit b, input int dly, input bit pz);
      bit g, hit, pp;
      g   = m_gpend;
      hit = w | b;
      pp  = pz & PAUSE_EN;
      for (int i = 0; i < dly; i++) begin
         n_chk++;
         if (o_move_req !== 1'b1) begin
            n_fail++;
            $display("FAIL req_held: got %b expected 1 at wait cycle %0d", o_move_req, i);
         end
         if (pz && i == 0) t_pause = 1'b1;
         cyc();
         t_pause = 1'b0;
      end
      t_ack = 1'b1; t_eat = e; t_wall = w; t_body = b;
      if (pz && dly == 0) t_pause = 1'b1;
      cyc();
      t_ack = 1'b0; t_eat = 1'b0; t_wall = 1'b0; t_body = 1'b0; t_pause = 1'b0;

      if (g) begin
         if (m_len < 127) m_len++;
         m_gpend = 1'b0;
      end
      if (hit) begin
         m_state = ST_OVER;
      end else if (e) begin
         if (m_score < 65535) m_score++;
         m_gpend = 1'b1;
         if (m_lvl < 3) m_lvl++;
         m_state = (m_score >= m_win) ? ST_WIN : (pp ? ST_PAUSE : ST_PLAY);
      end else begin
         m_state = pp ? ST_PAUSE : ST_PLAY;
      end

      n_chk++;
      if (o_state !== m_state) begin
         n_fail++; $display("FAIL ack_state: got %0d expected %0d", o_state, m_state);
      end
      n_chk++;
      if (o_score !== 16'(m_score)) begin
         n_fail++; $display("FAIL ack_score: got %0d expected %0d", o_score, m_score);
      end
      n_chk++;
      if (o_length !== 7'(m_len)) begin
         n_fail++; $display("FAIL ack_length: got %0d expected %0d", o_length, m_len);
      end
      n_chk++;
      if (o_level !== 4'(m_lvl)) begin
         n_fail++; $display("FAIL ack_level: got %0d expected %0d", o_level, m_lvl);
      end
      n_chk++;
      if ({o_move_req, o_grow, o_respawn} !== {1'b0, 1'b0, e & ~hit}) begin
         n_fail++; $display("FAIL ack_outputs: got req/grow/respawn %b expected %b",
                            {o_move_req, o_grow, o_respawn}, {1'b0, 1'b0, e & ~hit});
      end
      g_since = 0;
   endtask

   task automatic play_move(input bit e, input bit w, input bit b, input int dly, input bit pz);
      int n;
      wait_move(g_since, n);
      n_chk++;
      if (n !== exp_period(m_lvl)) begin
         n_fail++; $display("FAIL move_period: got %0d expected %0d", n, exp_period(m_lvl));
      end
      n_chk++;
      if (o_grow !== m_gpend) begin
         n_fail++; $display("FAIL move_grow: got %b expected %b", o_grow, m_gpend);
      end
      ack_phase(e, w, b, dly, pz);
   endtask

   task automatic start_game();
      t_start = 1'b1;
      cyc();
      t_start = 1'b0;
      n_chk++;
      if ({o_clear, o_state} !== {1'b1, 3'(ST_PLAY)}) begin
         n_fail++; $display("FAIL start_entry: got clear/state %b expected %b", {o_clear, o_state}, {1'b1, 3'(ST_PLAY)});
      end
      n_chk++;
      if ({o_score, o_length, o_level, o_move_req} !== 28'd0) begin
         n_fail++; $display("FAIL start_zero: got score %0d length %0d level %0d req %b expected zeros",
                            o_score, o_length, o_level, o_move_req);
      end
      cyc();
      n_chk++;
      if (o_clear !== 1'b0) begin
         n_fail++; $display("FAIL clear_width: got %b expected 0", o_clear);
      end
      m_state = ST_PLAY; m_score = 0; m_len = 0; m_lvl = 0; m_gpend = 1'b0;
      g_since = 1;
   endtask

   task automatic to_start();
      t_start = 1'b1;
      cyc();
      t_start = 1'b0;
      n_chk++;
      if ({o_clear, o_state} !== {1'b1, 3'(ST_START)}) begin
         n_fail++; $display("FAIL to_start: got clear/state %b expected %b", {o_clear, o_state}, {1'b1, 3'(ST_START)});
      end
      cyc();
      m_state = ST_START;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; sel = 1'b0;
      t_start = 1'b0; t_pause = 1'b0; t_ack = 1'b0; t_eat = 1'b0; t_wall = 1'b0; t_body = 1'b0;
      repeat (3) cyc();
      n_chk++;
      if (o_state !== 3'(ST_START)) begin
         n_fail++; $display("FAIL reset_state: got %0d expected %0d", o_state, ST_START);
      end
      n_chk++;
      if ({o_move_req, o_grow, o_respawn, o_clear} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_outputs: got %b expected 0000", {o_move_req, o_grow, o_respawn, o_clear});
      end
      n_chk++;
      if ({o_score, o_length, o_level} !== 27'd0) begin
         n_fail++; $display("FAIL reset_counts: got %0d/%0d/%0d expected 0/0/0", o_score, o_length, o_level);
      end
      reset_n = 1'b1;
      cyc();
   endtask

   task automatic test_first_move();
      m_win = 3;
      start_game();
      play_move(1'b0, 1'b0, 1'b0, 7, 1'b0);
   endtask

   task automatic test_eat_grow();
      play_move(1'b1, 1'b0, 1'b0, int'($urandom_range(0, 5)), 1'b0);
      play_move(1'b0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_collision();
      int hi;
      play_move(1'b1, 1'b0, 1'b1, 2, 1'b0);
      t_ack = 1'b1; t_eat = 1'b1;
      cyc();
      t_ack = 1'b0; t_eat = 1'b0;
      hi = 0;
      for (int i = 0; i < 25; i++) begin
         if (o_move_req) hi++;
         cyc();
      end
      n_chk++;
      if ({o_state, o_score, hi[0]} !== {3'(ST_OVER), 16'(m_score), 1'b0} || hi != 0) begin
         n_fail++; $display("FAIL over_frozen: got state %0d score %0d req_cycles %0d expected %0d %0d 0",
                            o_state, o_score, hi, ST_OVER, m_score);
      end
      to_start();
      start_game();
   endtask

   task automatic test_win();
      int hi;
      for (int i = 0; i < 3; i++)
         play_move(1'b1, 1'b0, 1'b0, int'($urandom_range(0, 3)), 1'b0);
      hi = 0;
      for (int i = 0; i < 30; i++) begin
         if (o_move_req) hi++;
         cyc();
      end
      n_chk++;
      if (o_state !== 3'(ST_WIN) || hi != 0) begin
         n_fail++; $display("FAIL win_hold: got state %0d req_cycles %0d expected %0d 0", o_state, hi, ST_WIN);
      end
      to_start();
   endtask

   task automatic test_random();
      bit e, w, b;
      int moves;
      for (int g = 0; g < 3; g++) begin
         start_game();
         moves = 0;
         while (m_state == ST_PLAY && moves < 12) begin
            e = ($urandom_range(0, 1) == 1);
            w = ($urandom_range(0, 9) == 0);
            b = ($urandom_range(0, 9) == 0);
            play_move(e, w, b, int'($urandom_range(0, 4)), 1'b0);
            moves++;
         end
         if (m_state == ST_PLAY) play_move(1'b0, 1'b1, 1'b0, 0, 1'b0);
         to_start();
      end
   endtask

   task automatic test_pause();
      int n, hi;
      start_game();
      repeat (9) cyc();
      t_pause = 1'b1;
      cyc();
      t_pause = 1'b0;
      if (PAUSE_EN) begin
         n_chk++;
         if (o_state !== 3'(ST_PAUSE)) begin
            n_fail++; $display("FAIL pause_enter: got %0d expected %0d", o_state, ST_PAUSE);
         end
         hi = 0;
         for (int i = 0; i < 50; i++) begin
            if (o_move_req) hi++;
            cyc();
         end
         n_chk++;
         if (hi != 0) begin
            n_fail++; $display("FAIL pause_frozen: got %0d request cycles expected 0", hi);
         end
         t_pause = 1'b1;
         cyc();
         t_pause = 1'b0;
         wait_move(0, n);
         n_chk++;
         if (n != 10) begin
            n_fail++; $display("FAIL pause_resume: got %0d expected 10", n);
         end
         ack_phase(1'b0, 1'b0, 1'b0, 2, 1'b1);
         t_pause = 1'b1;
         cyc();
         t_pause = 1'b0;
         n_chk++;
         if (o_state !== 3'(ST_PLAY)) begin
            n_fail++; $display("FAIL pause_leave: got %0d expected %0d", o_state, ST_PLAY);
         end
         m_state = ST_PLAY;
         g_since = 0;
      end else begin
         n_chk++;
         if (o_state !== 3'(ST_PLAY)) begin
            n_fail++; $display("FAIL pause_ignored: got %0d expected %0d", o_state, ST_PLAY);
         end
         wait_move(11, n);
         n_chk++;
         if (n != 20) begin
            n_fail++; $display("FAIL pause_no_effect: got %0d expected 20", n);
         end
         ack_phase(1'b0, 1'b0, 1'b0, 1, 1'b1);
      end
      play_move(1'b0, 1'b1, 1'b0, 0, 1'b0);
      to_start();
   endtask

   task automatic test_floor_and_sat();
      sel = 1'b1;
      m_win = 1000;
      cyc();
      start_game();
      for (int i = 0; i < 135; i++)
         play_move(1'b1, 1'b0, 1'b0, int'($urandom_range(0, 3)), 1'b0);
      play_move(1'b0, 1'b0, 1'b1, 0, 1'b0);
      to_start();
      sel = 1'b0;
      m_win = 3;
      cyc();
   endtask

   task automatic test_reset_mid_wait();
      int n, hi;
      start_game();
      wait_move(g_since, n);
      n_chk++;
      if (o_move_req !== 1'b1) begin
         n_fail++; $display("FAIL mid_wait_req: got %b expected 1", o_move_req);
      end
      #3 reset_n = 1'b0;
      #1;
      n_chk++;
      if ({o_move_req, o_state} !== {1'b0, 3'(ST_START)}) begin
         n_fail++; $display("FAIL async_reset: got req/state %b expected %b", {o_move_req, o_state}, {1'b0, 3'(ST_START)});
      end
      cyc();
      reset_n = 1'b1;
      t_ack = 1'b1; t_eat = 1'b1;
      cyc();
      t_ack = 1'b0; t_eat = 1'b0;
      hi = 0;
      for (int i = 0; i < 25; i++) begin
         if (o_move_req) hi++;
         cyc();
      end
      n_chk++;
      if (o_state !== 3'(ST_START) || o_score !== 16'd0 || hi != 0) begin
         n_fail++; $display("FAIL stray_ack: got state %0d score %0d req_cycles %0d expected %0d 0 0",
                            o_state, o_score, hi, ST_START);
      end
   endtask

   initial begin
      test_reset();
      test_first_move();
      test_eat_grow();
      test_collision();
      test_win();
      test_random();
      test_pause();
      test_floor_and_sat();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
